// File: rtl/matrix_stream_loader.sv
// Streams a row-major m x n matrix into storage, issuing one registered write per accepted element.
// Optional feature: define MATRIX_LOADER_TRANSPOSE_EN to add a transpose input that swaps write addresses.
module matrix_stream_loader #(
    parameter int DATA_W  = 32,
    parameter int DIM_W   = 8,
    parameter int MAX_DIM = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  m_dim,
    input  logic [DIM_W-1:0]  n_dim,
`ifdef MATRIX_LOADER_TRANSPOSE_EN
    input  logic              transpose,
`endif
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [DIM_W-1:0]  wr_m_addr,
    output logic [DIM_W-1:0]  wr_n_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH
    } state_e;

    state_e              state_q, state_d;
    logic [DIM_W-1:0]    m_q, m_d, n_q, n_d;
    logic [DIM_W-1:0]    row_q, row_d, col_q, col_d;
    logic                trans_q, trans_d;
    logic                wr_en_q, wr_en_d, err_q, err_d;
    logic [DIM_W-1:0]    wr_m_q, wr_m_d, wr_n_q, wr_n_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                accept, last_col, last_row, dims_bad, trans_in;

    localparam logic [DIM_W:0] MAX_LIM = (DIM_W+1)'(MAX_DIM);

    function automatic logic shape_bad(input logic [DIM_W-1:0] rows, input logic [DIM_W-1:0] cols);
        return (rows == '0) || (cols == '0) || ({1'b0, rows} > MAX_LIM) || ({1'b0, cols} > MAX_LIM);
    endfunction

`ifdef MATRIX_LOADER_TRANSPOSE_EN
    assign trans_in = transpose;
    assign dims_bad = shape_bad(m_dim, n_dim) || (transpose && shape_bad(n_dim, m_dim));
`else
    assign trans_in = 1'b0;
    assign dims_bad = shape_bad(m_dim, n_dim);
`endif

    // Gating in_ready with abort keeps the handshake honest: an aborted cycle never consumes in_data.
    assign in_ready = (state_q == ST_LOAD) && !abort;
    assign accept   = in_valid && in_ready;
    assign last_col = (col_q == n_q - DIM_W'(1));
    assign last_row = (row_q == m_q - DIM_W'(1));

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        n_d       = n_q;
        row_d     = row_q;
        col_d     = col_q;
        trans_d   = trans_q;
        err_d     = 1'b0;
        wr_en_d   = 1'b0;
        wr_m_d    = wr_m_q;
        wr_n_d    = wr_n_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (dims_bad) begin
                        err_d = 1'b1;
                    end else begin
                        m_d     = m_dim;
                        n_d     = n_dim;
                        trans_d = trans_in;
                        row_d   = '0;
                        col_d   = '0;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_m_d    = trans_q ? col_q : row_q;
                    wr_n_d    = trans_q ? row_q : col_q;
                    wr_data_d = in_data;
                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + DIM_W'(1);
                        if (last_row) state_d = ST_FLUSH;
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            n_q       <= '0;
            row_q     <= '0;
            col_q     <= '0;
            trans_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            err_q     <= 1'b0;
            wr_m_q    <= '0;
            wr_n_q    <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            n_q       <= n_d;
            row_q     <= row_d;
            col_q     <= col_d;
            trans_q   <= trans_d;
            wr_en_q   <= wr_en_d;
            err_q     <= err_d;
            wr_m_q    <= wr_m_d;
            wr_n_q    <= wr_n_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_m_addr = wr_m_q;
    assign wr_n_addr = wr_n_q;
    assign wr_data   = wr_data_q;
    assign err       = err_q;
    assign busy      = (state_q != ST_IDLE);
    // The last write is already registered when FLUSH is entered, so done lines up with it.
    assign done      = (state_q == ST_FLUSH) && !abort;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed self-checking bench for matrix_stream_loader; a negedge monitor logs writes, done and err.
module tb_matrix_stream_loader;

    localparam int DATA_W = 32;
    localparam int DIM_W  = 8;

    logic              clk = 1'b0;
    logic              reset, start, abort, in_valid;
    logic [DIM_W-1:0]  m_dim, n_dim;
    logic [DATA_W-1:0] in_data;
    logic              in_ready, wr_en, busy, done, err;
    logic [DIM_W-1:0]  wr_m_addr, wr_n_addr;
    logic [DATA_W-1:0] wr_data;
`ifdef MATRIX_LOADER_TRANSPOSE_EN
    logic              transpose = 1'b0;
`endif

    matrix_stream_loader #(.DATA_W(DATA_W), .DIM_W(DIM_W), .MAX_DIM(128)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .m_dim     (m_dim),
        .n_dim     (n_dim),
`ifdef MATRIX_LOADER_TRANSPOSE_EN
        .transpose (transpose),
`endif
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_m_addr (wr_m_addr),
        .wr_n_addr (wr_n_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    logic [47:0] wq[$];
    int          wcyc[$];
    int          cyc = 0, done_cnt = 0, done_cyc = 0, done_nowr = 0, err_cnt = 0;
    bit          busy_seen = 0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            if (wr_en) begin
                wq.push_back({wr_m_addr, wr_n_addr, wr_data});
                wcyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (!wr_en) done_nowr++;
            end
            if (err) err_cnt++;
            if (busy) busy_seen = 1;
        end
    end

    task automatic clear_log();
        wq.delete();
        wcyc.delete();
        done_cnt = 0; done_nowr = 0; err_cnt = 0; busy_seen = 0;
    endtask

    task automatic start_load(input int m, input int n);
        start = 1'b1;
        m_dim = DIM_W'(m);
        n_dim = DIM_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offers elements k+1 until cnt are accepted; toggle=1 drops in_valid every other cycle.
    task automatic feed(input int cnt, input bit toggle);
        int k = 0;
        int c = 0;
        while (k < cnt && c < 100) begin
            in_valid = toggle ? ((c % 2) == 0) : 1'b1;
            in_data  = DATA_W'(k + 1);
            @(negedge clk);
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
            c++;
        end
        in_valid = 1'b0;
        if (k < cnt) check("feed_timeout", 64'(k), 64'(cnt));
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        check("idle_timeout", 64'(ok), 64'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_write(input string tag, input int idx, input int m, input int n, input int d);
        if (idx < wq.size()) check(tag, 64'(wq[idx]), {16'd0, 8'(m), 8'(n), 32'(d)});
        else check({tag, "_missing"}, 64'(wq.size()), 64'(idx + 1));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        m_dim = '0; n_dim = '0; in_data = '0;
        #3;
        check("reset_outputs", 64'({in_ready, wr_en, wr_m_addr, wr_n_addr, wr_data, busy, done, err}), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // 2x3 streaming load, in_valid held high
        clear_log();
        start_load(2, 3);
        feed(6, 1'b0);
        wait_idle();
        check("s23_count", 64'(wq.size()), 64'd6);
        check_write("s23_w0", 0, 0, 0, 1);
        check_write("s23_w1", 1, 0, 1, 2);
        check_write("s23_w2", 2, 0, 2, 3);
        check_write("s23_w3", 3, 1, 0, 4);
        check_write("s23_w4", 4, 1, 1, 5);
        check_write("s23_w5", 5, 1, 2, 6);
        if (wcyc.size() == 6) begin
            check("s23_consecutive", 64'(wcyc[5] - wcyc[0]), 64'd5);
            check("s23_done_with_last", 64'(done_cyc), 64'(wcyc[5]));
        end
        check("s23_done_cnt", 64'(done_cnt), 64'd1);
        check("s23_done_nowr", 64'(done_nowr), 64'd0);

        // Illegal dimensions: zero rows, then too many columns
        clear_log();
        start_load(0, 3);
        repeat (3) @(posedge clk); #1;
        check("err_m0_pulse", 64'(err_cnt), 64'd1);
        check("err_m0_busy", 64'(busy_seen), 64'd0);
        check("err_m0_writes", 64'(wq.size()), 64'd0);
        clear_log();
        start_load(2, 129);
        repeat (3) @(posedge clk); #1;
        check("err_n129_pulse", 64'(err_cnt), 64'd1);
        check("err_n129_busy", 64'(busy_seen), 64'd0);
        check("err_n129_writes", 64'(wq.size()), 64'd0);

        // 2x2 with in_valid toggling and a start (1x1) held while busy
        clear_log();
        start_load(2, 2);
        start = 1'b1; m_dim = 8'd1; n_dim = 8'd1;
        feed(4, 1'b1);
        start = 1'b0;
        wait_idle();
        check("tog_count", 64'(wq.size()), 64'd4);
        check_write("tog_w0", 0, 0, 0, 1);
        check_write("tog_w1", 1, 0, 1, 2);
        check_write("tog_w2", 2, 1, 0, 3);
        check_write("tog_w3", 3, 1, 1, 4);
        check("tog_done_cnt", 64'(done_cnt), 64'd1);

        // 3x3 aborted after the 4th accepted element; the same-cycle element is refused
        clear_log();
        start_load(3, 3);
        feed(4, 1'b0);
        abort = 1'b1; in_valid = 1'b1; in_data = 32'd99;
        @(negedge clk);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk); #1;
        check("abort_count", 64'(wq.size()), 64'd4);
        check_write("abort_w3", 3, 1, 0, 4);
        check("abort_no_done", 64'(done_cnt), 64'd0);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        clear_log();
        start_load(1, 1);
        feed(1, 1'b0);
        wait_idle();
        check("one_count", 64'(wq.size()), 64'd1);
        check_write("one_w0", 0, 0, 0, 1);
        check("one_done", 64'(done_cnt), 64'd1);

        // Reset in the middle of a 4x4 load
        clear_log();
        start_load(4, 4);
        feed(5, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_outputs", 64'({in_ready, wr_en, wr_m_addr, wr_n_addr, wr_data, busy, done, err}), 64'd0);
        check("rst_mid_no_done", 64'(done_cnt), 64'd0);
        check("rst_mid_writes", 64'(wq.size()), 64'd4);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_log();
        start_load(2, 2);
        feed(4, 1'b0);
        wait_idle();
        check("post_rst_count", 64'(wq.size()), 64'd4);
        check_write("post_rst_w3", 3, 1, 1, 4);
        check("post_rst_done", 64'(done_cnt), 64'd1);

`ifdef MATRIX_LOADER_TRANSPOSE_EN
        clear_log();
        transpose = 1'b1;
        start_load(2, 3);
        transpose = 1'b0;
        feed(6, 1'b0);
        wait_idle();
        check("tr_count", 64'(wq.size()), 64'd6);
        check_write("tr_w0", 0, 0, 0, 1);
        check_write("tr_w1", 1, 1, 0, 2);
        check_write("tr_w2", 2, 2, 0, 3);
        check_write("tr_w3", 3, 0, 1, 4);
        check_write("tr_w4", 4, 1, 1, 5);
        check_write("tr_w5", 5, 2, 1, 6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
